nibble_arbiter: RTL and testbench
=================================

// Module: nibble_arbiter
// PURPOSE
//  Shares one nibble_top datapath between 2 requesters (REQ/GNT handshake).
//  Registers the granted operands onto the datapath inputs and tags each issue in a DP_LATENCY-deep pipe.
//  Routes the returning DATA_OUT back to the owning requester with a 1-cycle RESP_VALID pulse.
//  Supports LOCK for back-to-back ownership. Fully pipelined: max 1 issue per cycle.
// PARAMETERS
//  DP_LATENCY  3  CLK edges from DP_* register update to the matching DP_DATA_OUT (selector4 + nibble_mayor + out flop)
// PORTS
//  CLK          in   1   single clock; all logic on posedge
//  RESET_L      in   1   synchronous reset, active-low
//  REQ          in   2   REQ[i]: requester i has a valid operation
//  LOCK         in   2   LOCK[i] with accepted REQ[i]: keep ownership after this issue
//  DATA_A0/1    in   32  operand A of requester 0/1
//  DATA_B0/1    in   32  operand B of requester 0/1
//  SEL_A0/1     in   12  SEL_A of requester 0/1
//  SEL_B0/1     in   12  SEL_B of requester 0/1
//  SEL_AB0/1    in   4   SEL_AB of requester 0/1
//  GNT          out  2   combinational, one-hot or 0; REQ[i]&GNT[i] = accept
//  DP_DATA_A    out  32  registered to nibble_top DATA_A
//  DP_DATA_B    out  32  registered to nibble_top DATA_B
//  DP_SEL_A     out  12  registered to nibble_top SEL_A
//  DP_SEL_B     out  12  registered to nibble_top SEL_B
//  DP_SEL_AB    out  4   registered to nibble_top SEL_AB
//  DP_DATA_OUT  in   4   nibble_top DATA_OUT
//  RESP_VALID   out  2   registered, 1-cycle pulse to the owning requester
//  RESP_DATA    out  4   registered result; 0 when RESP_VALID==0
// BEHAVIOUR
//  Reset (RESET_L==0 at posedge)
//   - All DP_* = 0, RESP_VALID = 0, RESP_DATA = 0.
//   - Tag pipe cleared; FSM = IDLE; RR pointer = requester 0 preferred.
//   - Reset mid-operation drops every in-flight op: no RESP_VALID for them, ever.
//   - GNT = 0 while RESET_L==0.
//  FSM
//   - States: IDLE, OWN0, OWN1.
//   - IDLE: grant per arbitration policy. On accept by i with LOCK[i]=1 -> OWNi; else stay IDLE.
//   - OWNi: GNT = {i} only; other requester is blocked even if requesting.
//   - Leaves OWNi -> IDLE on the first cycle where REQ[i]==0, or on accept with LOCK[i]==0.
//   - REQ[i] low in OWNi yields no grant that cycle (1-cycle arbitration bubble); IDLE is entered next cycle.
//  Issue
//   - On accept, the next posedge loads DP_* from requester i's operands.
//   - Same edge shifts {valid=1, id=i} into tag pipe stage 0.
//   - No accept: DP_* hold their values and a bubble {valid=0} enters the pipe.
//  Return
//   - Tag stage DP_LATENCY-1 aligns with DP_DATA_OUT.
//   - If that tag is valid: next posedge sets RESP_VALID[id]=1 and RESP_DATA=DP_DATA_OUT.
//   - Total accept-to-RESP_VALID latency = DP_LATENCY+1 cycles; one response per cycle, in issue order.
//  Requester contract
//   - Requester holds REQ and operands stable until accept; REQ may drop without accept (no effect).
//   - REQ[0]&REQ[1] same cycle: exactly one granted (policy below); loser keeps waiting.
// CONFIGURATION
//  NIBBLE_ARB_RR_EN defined
//   - IDLE arbitration is round-robin; pointer flips to the other requester after every accept.
//   - Pointer is unchanged while in OWNi.
//  NIBBLE_ARB_RR_EN undefined
//   - Fixed priority: requester 0 wins every IDLE tie; no pointer register.
// STRUCTURE
//  Shared package nibble_arb_pkg.vh:
//   - FSM state encodings ST_IDLE/ST_OWN0/ST_OWN1.
//   - Requester-id width NB_ARB_IDW=1; default DP_LATENCY.
//  Sub-module nibble_arb_tagpipe: DP_LATENCY-stage {valid,id} shift register with synchronous clear.
//  Integration: instantiated beside nibble_top; the two share CLK and RESET_L.
// TESTING
//  1 Reset
//   - RESET_L=0 for 2 cycles with REQ=2'b11 -> GNT=0, RESP_VALID=0, all DP_*=0.
//  2 Single issue
//   - Single REQ0, DATA_A0=DATA_B0=32'h9999_9999, any SELs.
//   - GNT=2'b01; RESP_VALID=2'b01, RESP_DATA=4'h9 exactly 4 cycles after accept.
//  3 Back-to-back
//   - REQ=2'b11 held 4 cycles; req0 operands all-9s, req1 operands 32'h0.
//   - RR_EN: grants 01,10,01,10, responses 9,0,9,0 in order.
//   - Fixed: 4 grants to req0, req1 starved.
//  4 Lock
//   - LOCK1=1 with REQ1 3 cycles while REQ0=1 -> GNT=10 all 3 cycles.
//   - REQ1 drops -> 1 bubble, then GNT=01.
//  5 Reset mid-flight
//   - 2 accepts, then RESET_L=0 one cycle after the 2nd accept.
//   - No RESP_VALID pulse for either op; next issue responds normally.
//  6 Scoreboard
//   - 2000 random REQ/LOCK/operand cycles against a behavioural nibble_top model.
//   - Every accept gets exactly one response, correct id and data, none lost or duplicated.

Source files
------------

// File: rtl/nibble_arb_pkg.sv
// ============================================================================
// Module   : nibble_arb_pkg
// Purpose  : Shared types and constants for the nibble_top request arbiter:
//            FSM state encoding, requester-id width, default datapath latency
//            and the operand bundle carried onto the datapath inputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package nibble_arb_pkg;

  // Ownership FSM: IDLE arbitrates, OWNi locks the datapath to requester i
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int NB_ARB_IDW        = 1;
  localparam int NB_ARB_DP_LATENCY = 3;

  // One requester's operation as presented to nibble_top
  typedef struct packed {
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [11:0] sel_a;
    logic [11:0] sel_b;
    logic [3:0]  sel_ab;
  } arb_op_t;

  // Requester id to one-hot response/grant vector
  function automatic logic [1:0] id_to_onehot(input logic [NB_ARB_IDW-1:0] id);
    return 2'b01 << id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_arb_tagpipe.sv
// ============================================================================
// Module   : nibble_arb_tagpipe
// Purpose  : DP_LATENCY-stage {valid,id} shift register that travels beside
//            the nibble_top pipeline so each returning result can be routed
//            to the requester that issued it. Synchronous active-low clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_arb_tagpipe
  import nibble_arb_pkg::*;
#(
  parameter int DP_LATENCY = NB_ARB_DP_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  input  logic                  IN_VALID,
  input  logic [NB_ARB_IDW-1:0] IN_ID,
  output logic                  OUT_VALID,
  output logic [NB_ARB_IDW-1:0] OUT_ID
);

  logic [DP_LATENCY-1:0]                 valid_d, valid_q;
  logic [DP_LATENCY-1:0][NB_ARB_IDW-1:0] id_d, id_q;

  // Next stage contents: new tag enters stage 0, every other stage shifts up
  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    valid_d[0] = IN_VALID;
    id_d[0]    = IN_ID;
    for (int k = 1; k < DP_LATENCY; k++) begin
      valid_d[k] = valid_q[k-1];
      id_d[k]    = id_q[k-1];
    end
  end

  // Stage registers; reset discards every in-flight tag
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign OUT_VALID = valid_q[DP_LATENCY-1];
  assign OUT_ID    = id_q[DP_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/nibble_arbiter.sv
// ============================================================================
// Module   : nibble_arbiter
// Purpose  : Shares one nibble_top datapath between two requesters with a
//            REQ/GNT handshake, LOCK for back-to-back ownership, registered
//            operand issue and tagged routing of results back to the owner.
//            Build option NIBBLE_ARB_RR_EN: round-robin IDLE arbitration;
//            when undefined, requester 0 has fixed priority.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int DP_LATENCY = NB_ARB_DP_LATENCY
) (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic [1:0]  REQ,
  input  logic [1:0]  LOCK,
  input  logic [31:0] DATA_A0,
  input  logic [31:0] DATA_A1,
  input  logic [31:0] DATA_B0,
  input  logic [31:0] DATA_B1,
  input  logic [11:0] SEL_A0,
  input  logic [11:0] SEL_A1,
  input  logic [11:0] SEL_B0,
  input  logic [11:0] SEL_B1,
  input  logic [3:0]  SEL_AB0,
  input  logic [3:0]  SEL_AB1,
  output logic [1:0]  GNT,
  output logic [31:0] DP_DATA_A,
  output logic [31:0] DP_DATA_B,
  output logic [11:0] DP_SEL_A,
  output logic [11:0] DP_SEL_B,
  output logic [3:0]  DP_SEL_AB,
  input  logic [3:0]  DP_DATA_OUT,
  output logic [1:0]  RESP_VALID,
  output logic [3:0]  RESP_DATA
);

  arb_state_e            state_d, state_q;
  logic [1:0]            gnt;
  logic                  accept;
  logic [NB_ARB_IDW-1:0] acc_id;
  arb_op_t               op0, op1;
  arb_op_t               dp_d, dp_q;
  logic                  tp_valid;
  logic [NB_ARB_IDW-1:0] tp_id;
  logic [1:0]            resp_valid_d, resp_valid_q;
  logic [3:0]            resp_data_d, resp_data_q;

`ifdef NIBBLE_ARB_RR_EN
  // rr_q==1 means requester 1 wins the next IDLE tie
  logic rr_d, rr_q;
`endif

  assign op0 = '{data_a: DATA_A0, data_b: DATA_B0, sel_a: SEL_A0,
                 sel_b: SEL_B0, sel_ab: SEL_AB0};
  assign op1 = '{data_a: DATA_A1, data_b: DATA_B1, sel_a: SEL_A1,
                 sel_b: SEL_B1, sel_ab: SEL_AB1};

  // Grant selection and ownership FSM next state
  always_comb begin
    gnt     = 2'b00;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef NIBBLE_ARB_RR_EN
        if (REQ == 2'b11) gnt = rr_q ? 2'b10 : 2'b01;
        else              gnt = REQ;
`else
        if (REQ[0])      gnt = 2'b01;
        else if (REQ[1]) gnt = 2'b10;
`endif
      end
      // An owner that drops REQ gets no grant: the cycle is a bubble
      ST_OWN0: gnt = {1'b0, REQ[0]};
      ST_OWN1: gnt = {REQ[1], 1'b0};
      default: gnt = 2'b00;
    endcase
    if (!RESET_L) gnt = 2'b00;

    accept = |(REQ & gnt);
    acc_id = gnt[1];

    case (state_q)
      ST_IDLE: if (accept && LOCK[acc_id]) state_d = acc_id ? ST_OWN1 : ST_OWN0;
      ST_OWN0: if (!REQ[0] || !LOCK[0])    state_d = ST_IDLE;
      ST_OWN1: if (!REQ[1] || !LOCK[1])    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef NIBBLE_ARB_RR_EN
  // Pointer moves away from whoever won an IDLE arbitration; frozen while owned
  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_IDLE && accept) rr_d = ~acc_id;
  end

  // Round-robin pointer register, requester 0 preferred out of reset
  always_ff @(posedge CLK) begin
    if (!RESET_L) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`endif

  // Datapath operands: load the winner's operation, otherwise hold
  always_comb begin
    dp_d = dp_q;
    if (accept) dp_d = acc_id ? op1 : op0;
  end

  // Result routing: the oldest tag lines up with DP_DATA_OUT
  always_comb begin
    resp_valid_d = 2'b00;
    resp_data_d  = 4'h0;
    if (tp_valid) begin
      resp_valid_d = id_to_onehot(tp_id);
      resp_data_d  = DP_DATA_OUT;
    end
  end

  // FSM, datapath operand and response registers
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q      <= ST_IDLE;
      dp_q         <= '0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= 4'h0;
    end else begin
      state_q      <= state_d;
      dp_q         <= dp_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  nibble_arb_tagpipe #(
    .DP_LATENCY (DP_LATENCY)
  ) u_tagpipe (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .IN_VALID  (accept),
    .IN_ID     (acc_id),
    .OUT_VALID (tp_valid),
    .OUT_ID    (tp_id)
  );

  assign GNT        = gnt;
  assign DP_DATA_A  = dp_q.data_a;
  assign DP_DATA_B  = dp_q.data_b;
  assign DP_SEL_A   = dp_q.sel_a;
  assign DP_SEL_B   = dp_q.sel_b;
  assign DP_SEL_AB  = dp_q.sel_ab;
  assign RESP_VALID = resp_valid_q;
  assign RESP_DATA  = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_arbiter.sv
// ============================================================================
// Module   : tb_nibble_arbiter
// Purpose  : Self-checking bench for nibble_arbiter with a behavioural
//            nibble_top stand-in and a response scoreboard.
//            Build option NIBBLE_ARB_RR_EN selects the expected arbitration.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nibble_arbiter;
  import nibble_arb_pkg::*;

  localparam int LAT = NB_ARB_DP_LATENCY;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic [1:0]  REQ, LOCK;
  logic [31:0] DATA_A0, DATA_A1, DATA_B0, DATA_B1;
  logic [11:0] SEL_A0, SEL_A1, SEL_B0, SEL_B1;
  logic [3:0]  SEL_AB0, SEL_AB1;
  logic [1:0]  GNT;
  logic [31:0] DP_DATA_A, DP_DATA_B;
  logic [11:0] DP_SEL_A, DP_SEL_B;
  logic [3:0]  DP_SEL_AB, DP_DATA_OUT;
  logic [1:0]  RESP_VALID;
  logic [3:0]  RESP_DATA;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  nibble_arbiter dut (
    .CLK (CLK), .RESET_L (RESET_L), .REQ (REQ), .LOCK (LOCK),
    .DATA_A0 (DATA_A0), .DATA_A1 (DATA_A1), .DATA_B0 (DATA_B0), .DATA_B1 (DATA_B1),
    .SEL_A0 (SEL_A0), .SEL_A1 (SEL_A1), .SEL_B0 (SEL_B0), .SEL_B1 (SEL_B1),
    .SEL_AB0 (SEL_AB0), .SEL_AB1 (SEL_AB1), .GNT (GNT),
    .DP_DATA_A (DP_DATA_A), .DP_DATA_B (DP_DATA_B), .DP_SEL_A (DP_SEL_A),
    .DP_SEL_B (DP_SEL_B), .DP_SEL_AB (DP_SEL_AB), .DP_DATA_OUT (DP_DATA_OUT),
    .RESP_VALID (RESP_VALID), .RESP_DATA (RESP_DATA)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural nibble_top: pick a nibble of A and of B, return max (or min)
  function automatic logic [3:0] dp_f(input logic [31:0] a, input logic [31:0] b,
                                      input logic [11:0] sa, input logic [11:0] sb,
                                      input logic [3:0] sab);
    logic [3:0] na, nb;
    na = a[sa[2:0]*4 +: 4];
    nb = b[sb[2:0]*4 +: 4];
    if (sab[0]) return (na < nb) ? na : nb;
    return (na > nb) ? na : nb;
  endfunction

  // Datapath stand-in: LAT-1 register stages after the DP_* inputs
  logic [LAT-2:0][3:0] dpm_q;
  always @(posedge CLK) begin
    if (!RESET_L) dpm_q <= '0;
    else begin
      dpm_q[0] <= dp_f(DP_DATA_A, DP_DATA_B, DP_SEL_A, DP_SEL_B, DP_SEL_AB);
      for (int k = 1; k < LAT-1; k++) dpm_q[k] <= dpm_q[k-1];
    end
  end
  assign DP_DATA_OUT = dpm_q[LAT-2];

  // Scoreboard
  typedef struct {
    logic [1:0] oh;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc_n = 0;
  logic [1:0] last_acc = 2'b00;
  logic       mon_en = 1'b0;

  initial begin
    @(posedge CLK);
    #1 mon_en = 1'b1;
  end

  always @(negedge CLK) begin
    exp_t e;
    cyc_n++;
    if (mon_en) begin
      if (RESP_VALID != 2'b00) begin
        if (sb_q.size() == 0) check_eq("resp_spurious", RESP_VALID, 0);
        else begin
          e = sb_q.pop_front();
          check_eq("resp_id", RESP_VALID, e.oh);
          check_eq("resp_data", RESP_DATA, e.data);
          check_eq("resp_latency", cyc_n - e.cyc, LAT + 1);
        end
      end else begin
        check_eq("resp_data_idle", RESP_DATA, 0);
      end
      check_eq("gnt_onehot", ($countones(GNT) <= 1), 1);
      last_acc = REQ & GNT;
      if (last_acc == 2'b01)
        sb_q.push_back('{2'b01, dp_f(DATA_A0, DATA_B0, SEL_A0, SEL_B0, SEL_AB0), cyc_n});
      else if (last_acc == 2'b10)
        sb_q.push_back('{2'b10, dp_f(DATA_A1, DATA_B1, SEL_A1, SEL_B1, SEL_AB1), cyc_n});
      else if (last_acc != 2'b00)
        check_eq("accept_onehot", last_acc, 0);
      // Anything in flight at a reset edge is dropped by the design
      if (!RESET_L) sb_q.delete();
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    REQ     = 2'b00;
    LOCK    = 2'b00;
    step();
    RESET_L = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while (sb_q.size() != 0 && k < maxc) begin
      @(posedge CLK);
      k++;
    end
    check_eq("drain", sb_q.size(), 0);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [11:0] sa, input logic [11:0] sb, input logic [3:0] sab);
    if (i == 0) begin
      DATA_A0 = a; DATA_B0 = b; SEL_A0 = sa; SEL_B0 = sb; SEL_AB0 = sab;
    end else begin
      DATA_A1 = a; DATA_B1 = b; SEL_A1 = sa; SEL_B1 = sb; SEL_AB1 = sab;
    end
  endtask

  task automatic rand_op(input int i);
    set_op(i, $urandom, $urandom, 12'($urandom), 12'($urandom), 4'($urandom));
  endtask

  logic [1:0] exp3 [4];
  logic [1:0] pend;

  initial begin
    // 1: reset with both requesting
    RESET_L = 1'b0;
    REQ     = 2'b11;
    LOCK    = 2'b00;
    set_op(0, 32'h0, 32'h0, 12'h0, 12'h0, 4'h0);
    set_op(1, 32'h0, 32'h0, 12'h0, 12'h0, 4'h0);
    @(negedge CLK);
    check_eq("rst_gnt", GNT, 0);
    check_eq("rst_resp_valid", RESP_VALID, 0);
    check_eq("rst_resp_data", RESP_DATA, 0);
    check_eq("rst_dp_a", DP_DATA_A, 0);
    check_eq("rst_dp_b", DP_DATA_B, 0);
    check_eq("rst_dp_sel", {DP_SEL_A, DP_SEL_B, DP_SEL_AB}, 0);
    step();
    @(negedge CLK);
    check_eq("rst_gnt2", GNT, 0);
    step();
    RESET_L = 1'b1;
    REQ     = 2'b00;

    // 2: single issue from requester 0
    set_op(0, 32'h9999_9999, 32'h9999_9999, 12'h005, 12'h003, 4'h0);
    REQ = 2'b01;
    @(negedge CLK);
    check_eq("single_gnt", GNT, 2'b01);
    step();
    REQ = 2'b00;
    repeat (3) step();
    @(negedge CLK);
    check_eq("single_resp_valid", RESP_VALID, 2'b01);
    check_eq("single_resp_data", RESP_DATA, 4'h9);
    step();
    drain(10);

    // 3: back-to-back contention
    do_reset();
`ifdef NIBBLE_ARB_RR_EN
    exp3 = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp3 = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    set_op(0, 32'h9999_9999, 32'h9999_9999, 12'h999, 12'h999, 4'h9);
    set_op(1, 32'h0, 32'h0, 12'h0, 12'h0, 4'h0);
    REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check_eq($sformatf("b2b_gnt%0d", k), GNT, exp3[k]);
      step();
    end
    REQ = 2'b00;
    drain(10);

    // 4: lock held by requester 1 while requester 0 waits
    do_reset();
    rand_op(0);
    rand_op(1);
    REQ  = 2'b10;
    LOCK = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_eq($sformatf("lock_gnt%0d", k), GNT, 2'b10);
      step();
      REQ = 2'b11;
    end
    REQ  = 2'b01;
    LOCK = 2'b00;
    @(negedge CLK);
    check_eq("lock_bubble", GNT, 2'b00);
    step();
    @(negedge CLK);
    check_eq("lock_release", GNT, 2'b01);
    step();
    REQ = 2'b00;
    drain(10);

    // 5: reset while two operations are in flight
    do_reset();
    rand_op(0);
    rand_op(1);
    REQ = 2'b01;
    @(negedge CLK);
    check_eq("midrst_gnt0", GNT, 2'b01);
    step();
    REQ = 2'b10;
    @(negedge CLK);
    check_eq("midrst_gnt1", GNT, 2'b10);
    step();
    do_reset();
    repeat (LAT + 3) step();
    rand_op(0);
    REQ = 2'b01;
    step();
    REQ = 2'b00;
    drain(10);

    // 6: random traffic against the scoreboard
    do_reset();
    pend = 2'b00;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (last_acc[i]) pend[i] = 1'b0;
        if (pend[i]) begin
          if ($urandom_range(0, 99) < 3) begin
            pend[i] = 1'b0;
            REQ[i]  = 1'b0;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          rand_op(i);
          REQ[i]  = 1'b1;
          pend[i] = 1'b1;
        end else begin
          REQ[i] = 1'b0;
        end
        LOCK[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    REQ  = 2'b00;
    LOCK = 2'b00;
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
